fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of mem_program. Drives mem_program's clk/we/addr/data_in
//  and consumes its data_out. In RUN mode it sequences the PC and feeds an IF/ID register to decode.
//  In LOAD mode it forwards host program writes into mem_program.
//  Handles stall, branch redirect, halt and the program-load handshake.
// PARAMETERS
//  MEM_WIDTH    16  address width of mem_program (shared value from params_proc.v)
//  INSTR_WIDTH  32  instruction width (shared value from params_proc.v)
//  PC_INITIAL   0   first fetch address after start (shared value from params_proc.v)
// PORTS
//  clk            in   1            single clock, all state on posedge
//  rst            in   1            synchronous, active-high reset
//  prog_mode      in   1            host requests program-load mode
//  prog_we        in   1            host write strobe (LOAD only)
//  prog_addr      in   MEM_WIDTH    host write address
//  prog_data      in   INSTR_WIDTH  host write data
//  start          in   1            begin execution at PC_INITIAL (IDLE only)
//  halt           in   1            stop fetching, return to IDLE
//  stall          in   1            decode cannot accept; hold IF/ID and PC
//  branch_taken   in   1            redirect request, single-cycle pulse
//  branch_target  in   MEM_WIDTH    redirect address
//  mem_we         out  1            to mem_program.we
//  mem_addr       out  MEM_WIDTH    to mem_program.addr
//  mem_data_in    out  INSTR_WIDTH  to mem_program.data_in
//  mem_data_out   in   INSTR_WIDTH  from mem_program.data_out
//  instr          out  INSTR_WIDTH  IF/ID instruction
//  instr_pc       out  MEM_WIDTH    address of instr
//  instr_valid    out  1            instr is a real instruction
//  running        out  1            state == S_RUN
// BEHAVIOUR
//  - mem_program is a synchronous memory. It samples addr/we at posedge.
//    data_out = mem[addr sampled at the previous posedge]. Read latency is 1 cycle.
//  - Reset (wins over every other input): state=S_IDLE, pc_q=PC_INITIAL, req_valid_q=0, req_pc_q=0.
//    Also instr=0, instr_pc=0, instr_valid=0, mem_we=0.
//  - FSM states: S_IDLE, S_LOAD, S_RUN.
//    IDLE -> LOAD when prog_mode=1 (prog_mode has priority over start).
//    IDLE -> RUN when start=1; pc_q <= PC_INITIAL.
//    LOAD -> IDLE when prog_mode=0.
//    RUN -> IDLE when halt=1; req_valid_q and instr_valid are cleared.
//    In RUN, prog_mode and start are ignored.
//  - IDLE: mem_we=0, mem_addr=pc_q, instr_valid=0.
//  - LOAD: mem_we=prog_we, mem_addr=prog_addr, mem_data_in=prog_data. These are combinational pass-through.
//  - RUN: mem_we=0 and mem_data_in=0. Priority of events: halt > branch_taken > stall > normal.
//    * normal: mem_addr=pc_q. req_pc_q<=pc_q, req_valid_q<=1, pc_q<=pc_q+1.
//      IF/ID <= {mem_data_out, req_pc_q, req_valid_q}.
//    * stall: mem_addr=req_pc_q (replays the in-flight read so data_out stays valid next cycle).
//      pc_q, req_*, and IF/ID are all held. No instruction is lost or duplicated.
//    * branch_taken: pc_q<=branch_target, req_valid_q<=0, instr_valid<=0. Wins over a simultaneous stall.
//      Penalty is exactly 2 invalid cycles before the target instruction.
//  - Start latency: start is sampled at edge E0. The first mem_addr=PC_INITIAL is seen in the next cycle.
//    instr_valid=1 with instr_pc=PC_INITIAL after edge E2.
//  - PC arithmetic is MEM_WIDTH-bit unsigned. 2^MEM_WIDTH-1 + 1 wraps to 0 with no flag.
//  - instr/instr_pc keep stale values while instr_valid=0. Consumers must qualify with instr_valid.
// STRUCTURE
//  - MEM_WIDTH, INSTR_WIDTH, PC_INITIAL and the S_IDLE/S_LOAD/S_RUN encodings live in params_proc.v.
//  - Single module; no sub-module. FSM, PC/request register and IF/ID register are all inline.
//  - Top-level wiring: fetch_unit.mem_* <-> mem_program; fetch_unit.instr* -> decode.
// TESTING (bench instantiates fetch_unit + mem_program, PC_INITIAL=0)
//  - rst=1 for 2 cycles -> running=0, instr_valid=0, instr=0, mem_we=0 on every cycle of reset.
//  - Load: prog_mode=1, write 0x0050@0, 0x0850@1, 0x8152@2.
//    -> mem_we pulses match prog_we; a later run reads back all three words.
//  - start pulse -> instr_valid rises after E2.
//    Stream is (0,0x0050),(1,0x0850),(2,0x8152) on consecutive cycles.
//  - stall=1 for 2 cycles while instr_pc=1 -> instr=0x0850 held 3 cycles.
//    The next valid output is (2,0x8152); nothing is skipped.
//  - branch_taken=1 with target=0x0010 and stall=1 in the same cycle -> exactly 2 cycles with instr_valid=0.
//    Then instr_pc=0x0010, 0x0011, ...
//  - Set pc_q=0xFFFF via branch -> next instr_pc=0x0000.
//    halt mid-stream -> running=0 and instr_valid=0 the next cycle.
//    rst mid-run -> full reset values.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared processor parameters and fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int DEF_MEM_WIDTH   = 16;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_PC_INITIAL  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage driving a 1-cycle-latency program memory,
// with host program load, stall, branch redirect and halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int MEM_WIDTH   = DEF_MEM_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int PC_INITIAL  = DEF_PC_INITIAL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_mode,
    input  logic                   prog_we,
    input  logic [MEM_WIDTH-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [MEM_WIDTH-1:0]   branch_target,
    output logic                   mem_we,
    output logic [MEM_WIDTH-1:0]   mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_data_in,
    input  logic [INSTR_WIDTH-1:0] mem_data_out,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [MEM_WIDTH-1:0]   instr_pc,
    output logic                   instr_valid,
    output logic                   running
);

    localparam logic [MEM_WIDTH-1:0] PC0 = MEM_WIDTH'(PC_INITIAL);

    state_e                 state_q, state_d;
    logic [MEM_WIDTH-1:0]   pc_q, pc_d;
    logic [MEM_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                   req_valid_q, req_valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [MEM_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;

    logic in_load, in_run, run_stall;

    assign in_load   = state_q == S_LOAD;
    assign in_run    = state_q == S_RUN;
    assign run_stall = in_run && !halt && !branch_taken && stall;

    // A stall re-presents the in-flight address so data_out is still that word next cycle.
    assign mem_addr    = in_load ? prog_addr : run_stall ? req_pc_q : pc_q;
    assign mem_we      = in_load && prog_we && !rst;
    assign mem_data_in = in_load ? prog_data : '0;

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign running     = in_run;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        req_valid_d   = req_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            S_IDLE: begin
                instr_valid_d = 1'b0;
                if (prog_mode) begin
                    state_d = S_LOAD;
                end else if (start) begin
                    state_d     = S_RUN;
                    pc_d        = PC0;
                    req_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                instr_valid_d = 1'b0;
                if (!prog_mode) state_d = S_IDLE;
            end
            S_RUN: begin
                if (halt) begin
                    state_d       = S_IDLE;
                    req_valid_d   = 1'b0;
                    instr_valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d          = branch_target;
                    req_valid_d   = 1'b0;
                    instr_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d          = pc_q + MEM_WIDTH'(1);
                    req_pc_d      = pc_q;
                    req_valid_d   = 1'b1;
                    instr_d       = mem_data_out;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = req_valid_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= PC0;
            req_pc_q      <= '0;
            req_valid_q   <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            req_valid_q   <= req_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule
